// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and sizing helpers for the multi-limb add sequencer.
package wide_add_pkg;

    localparam int LIMB_W = 64;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} seqState_t;

    function automatic int limbCount(input int width);
        return width / LIMB_W;
    endfunction

    // At least one bit so single-limb / tiny-timeout builds still get a register.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Request/result channel between the integer issue logic and the sequencer.
interface wide_add_if #(
    parameter int WIDTH = 256
);
    logic             iValid;
    logic             oReady;
    logic             iSub;
    logic [WIDTH-1:0] iX;
    logic [WIDTH-1:0] iY;
    logic             iCarryIn;
    logic             oValid;
    logic [WIDTH-1:0] oZ;
    logic             oCarryOut;
    logic             oError;

    modport master (
        output iValid, iSub, iX, iY, iCarryIn,
        input  oReady, oValid, oZ, oCarryOut, oError
    );

    modport slave (
        input  iValid, iSub, iX, iY, iCarryIn,
        output oReady, oValid, oZ, oCarryOut, oError
    );
endinterface

// File: rtl/wide_add_sequencer_watchdog.sv
// Cycle counter that flags a stalled adder; counts the ISSUE cycle as cycle 0.
module add_watchdog
    import wide_add_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = cntWidth(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn || clear)
            count <= '0;
        else if (enable && count != LAST)
            count <= count + 1'b1;
    end

    assign expired = enable && (count == LAST);
endmodule

// File: rtl/wide_add_sequencer.sv
// Runs WIDTH-bit add/sub through the shared 64-bit adder one limb at a time,
// LS limb first, chaining carry; aborts with oError if the adder stalls.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WIDTH   = 256,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              resetn,
    wide_add_if.slave         req,
    output logic              oAdderValid,
    output logic [LIMB_W-1:0] oAdderX,
    output logic [LIMB_W-1:0] oAdderY,
    output logic              oAdderCarryIn,
    input  logic [LIMB_W-1:0] iAdderZ,
    input  logic              iAdderCarryOut,
    input  logic              iAdderReady
);
    localparam int LIMBS = limbCount(WIDTH);
    localparam int LW    = cntWidth(LIMBS);
    localparam logic [LW-1:0] LAST_LIMB = LW'(LIMBS - 1);

    seqState_t        state, stateNext;
    logic [WIDTH-1:0] xReg, yReg, zReg, xNext, yNext, zNext;
    logic             carry, carryNext;
    logic [LW-1:0]    limb, limbNext;

    logic             readyQ, validQ, errQ, coutQ;
    logic [WIDTH-1:0] zOutQ, zOutNext;
    logic             validNext, errNext, coutNext;
    logic             wdClear, wdEnable, wdExpired;

    assign req.oReady    = readyQ;
    assign req.oValid    = validQ;
    assign req.oZ        = zOutQ;
    assign req.oCarryOut = coutQ;
    assign req.oError    = errQ;

    add_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (wdClear),
        .enable  (wdEnable),
        .expired (wdExpired)
    );

    assign wdEnable = (state == ISSUE) || (state == WAIT);

    always_comb begin
        stateNext = state;
        xNext     = xReg;
        yNext     = yReg;
        zNext     = zReg;
        carryNext = carry;
        limbNext  = limb;
        errNext   = errQ;
        coutNext  = coutQ;
        zOutNext  = zOutQ;
        validNext = 1'b0;
        case (state)
            IDLE: if (req.iValid) begin
                // Subtract is X + ~Y + 1, so carry-out 1 means no borrow.
                xNext     = req.iX;
                yNext     = req.iSub ? ~req.iY : req.iY;
                carryNext = req.iSub | req.iCarryIn;
                zNext     = '0;
                limbNext  = '0;
                errNext   = 1'b0;
                coutNext  = 1'b0;
                zOutNext  = '0;
                stateNext = ISSUE;
            end
            ISSUE: stateNext = WAIT;
            WAIT: begin
                if (iAdderReady) begin
                    zNext[int'(limb)*LIMB_W +: LIMB_W] = iAdderZ;
                    carryNext = iAdderCarryOut;
                    if (limb == LAST_LIMB) begin
                        stateNext = DONE;
                    end else begin
                        limbNext  = limb + 1'b1;
                        stateNext = ISSUE;
                    end
                end else if (wdExpired) begin
                    errNext   = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (stateNext == DONE) begin
            validNext = 1'b1;
            zOutNext  = zNext;
            coutNext  = errNext ? 1'b0 : carryNext;
        end
        wdClear = (stateNext == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            xReg          <= '0;
            yReg          <= '0;
            zReg          <= '0;
            carry         <= 1'b0;
            limb          <= '0;
            readyQ        <= 1'b1;
            validQ        <= 1'b0;
            errQ          <= 1'b0;
            coutQ         <= 1'b0;
            zOutQ         <= '0;
            oAdderValid   <= 1'b0;
            oAdderX       <= '0;
            oAdderY       <= '0;
            oAdderCarryIn <= 1'b0;
        end else begin
            state       <= stateNext;
            xReg        <= xNext;
            yReg        <= yNext;
            zReg        <= zNext;
            carry       <= carryNext;
            limb        <= limbNext;
            readyQ      <= (stateNext == IDLE);
            validQ      <= validNext;
            errQ        <= errNext;
            coutQ       <= coutNext;
            zOutQ       <= zOutNext;
            oAdderValid <= (stateNext == ISSUE);
            if (stateNext == ISSUE) begin
                oAdderX       <= xNext[int'(limbNext)*LIMB_W +: LIMB_W];
                oAdderY       <= yNext[int'(limbNext)*LIMB_W +: LIMB_W];
                oAdderCarryIn <= carryNext;
            end
        end
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Random + directed bench: stub adder with programmable latency/hang, arithmetic golden model.
module tb_wide_add_sequencer;
    localparam int W = 256;
    localparam int TO = 8;
    localparam int LIMBS = W / 64;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    wide_add_if #(.WIDTH(W)) req();
    logic        aValid, aCin, aCout, aReady;
    logic [63:0] aX, aY, aZ;

    wide_add_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .req            (req),
        .oAdderValid    (aValid),
        .oAdderX        (aX),
        .oAdderY        (aY),
        .oAdderCarryIn  (aCin),
        .iAdderZ        (aZ),
        .iAdderCarryOut (aCout),
        .iAdderReady    (aReady)
    );

    int checks = 0, failures = 0, cyc = 0;
    int la = 2, hangLimb = -1, cnt = 0;
    bit spurious = 0, pend = 0;
    logic [63:0] sZ;
    logic        sC;
    int issueCnt = 0, validCnt = 0, validCyc = 0;
    int          issueCyc[$];
    logic        issueCin[$];
    logic [63:0] issueY[$];
    logic [W-1:0] gotZ;
    logic         gotC, gotE;

    task automatic chk(input string tag, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] randW();
        logic [W-1:0] r;
        for (int i = 0; i < W/32; i++) r[32*i +: 32] = $urandom;
        case ($urandom_range(0, 5))
            0: r = '1;
            1: r = '0;
            default: ;
        endcase
        return r;
    endfunction

    // One clock: observe just after the edge, run the stub adder and monitor.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        aReady = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                aReady = 1'b1; aZ = sZ; aCout = sC; pend = 0;
            end
        end
        if (aValid) begin
            issueCyc.push_back(cyc);
            issueCin.push_back(aCin);
            issueY.push_back(aY);
            if (issueCnt != hangLimb) begin
                {sC, sZ} = {1'b0, aX} + {1'b0, aY} + 65'(aCin);
                pend = 1; cnt = la;
            end
            issueCnt++;
        end
        if (!pend && !aReady && spurious && req.oReady && $urandom_range(0, 2) == 0) begin
            aReady = 1'b1; aZ = {$urandom, $urandom}; aCout = 1'b1;
        end
        if (req.oValid) begin
            validCnt++; validCyc = cyc;
            gotZ = req.oZ; gotC = req.oCarryOut; gotE = req.oError;
        end
    endtask

    task automatic rstChk(input string tag);
        chk({tag, ":oReady"}, req.oReady, 1);
        chk({tag, ":oValid"}, req.oValid, 0);
        chk({tag, ":oError"}, req.oError, 0);
        chk({tag, ":oZ"}, req.oZ, 0);
        chk({tag, ":oCarryOut"}, req.oCarryOut, 0);
        chk({tag, ":adderValid"}, aValid, 0);
        chk({tag, ":adderX"}, aX, 0);
        chk({tag, ":adderY"}, aY, 0);
        chk({tag, ":adderCin"}, aCin, 0);
    endtask

    task automatic startOp(input logic [W-1:0] x, y, input logic sub, cin);
        int guard;
        guard = 0;
        while (!req.oReady && guard < 50) begin tick(); guard++; end
        req.iValid = 1'b1; req.iX = x; req.iY = y; req.iSub = sub; req.iCarryIn = cin;
        issueCnt = 0;
        issueCyc.delete(); issueCin.delete(); issueY.delete();
    endtask

    task automatic runOp(input logic [W-1:0] x, y, input logic sub, cin,
                         input int lat, hang, input bit hold, input string tag);
        logic [W:0]   g, one;
        logic [W+1:0] m, xs, ys;
        logic [W-1:0] expZ, yp;
        logic         expC, expE, cinExp;
        int           acc, v0, guard, nIss;
        la = lat; hangLimb = hang;
        startOp(x, y, sub, cin);
        chk({tag, ":ready"}, req.oReady, 1);
        acc = cyc; v0 = validCnt; guard = 0;
        do begin
            tick(); guard++;
            req.iValid = hold; req.iX = randW(); req.iY = randW();
            req.iSub = 1'($urandom); req.iCarryIn = 1'($urandom);
        end while (validCnt == v0 && guard < 400);
        req.iValid = 1'b0;
        tick(); tick();
        chk({tag, ":pulses"}, validCnt - v0, 1);

        if (sub) begin
            expZ = x - y; expC = (x >= y);
        end else begin
            g = {1'b0, x} + {1'b0, y} + (W+1)'(cin);
            expZ = g[W-1:0]; expC = g[W];
        end
        yp = sub ? ~y : y;
        nIss = (hang >= 0) ? hang + 1 : LIMBS;
        chk({tag, ":issues"}, issueCnt, nIss);
        for (int i = 0; i < nIss && i < issueCyc.size(); i++) begin
            m  = (W+2)'(1) << (64*i);
            xs = (W+2)'(x) & (m - 1);
            ys = (W+2)'(y) & (m - 1);
            cinExp = sub ? (xs >= ys) : ((xs + ys + (W+2)'(cin)) >= m);
            chk($sformatf("%s:issueCyc%0d", tag, i), issueCyc[i] - acc, 1 + i*(lat+1));
            chk($sformatf("%s:cin%0d", tag, i), issueCin[i], cinExp);
            chk($sformatf("%s:limbY%0d", tag, i), issueY[i], yp[64*i +: 64]);
        end
        if (hang >= 0) begin
            one  = 1;
            g    = (one << (64*hang)) - 1;
            expZ = expZ & g[W-1:0];
            expC = 1'b0; expE = 1'b1;
            if (issueCyc.size() > hang)
                chk({tag, ":toLat"}, validCyc - issueCyc[hang], TO);
        end else begin
            expE = 1'b0;
            chk({tag, ":lat"}, validCyc - acc, LIMBS*(lat+1) + 1);
        end
        chk({tag, ":oZ"}, gotZ, expZ);
        chk({tag, ":oCarryOut"}, gotC, expC);
        chk({tag, ":oError"}, gotE, expE);
    endtask

    task automatic midReset();
        int guard, v0;
        la = 3; hangLimb = -1;
        startOp(randW(), randW(), 1'b0, 1'b1);
        v0 = validCnt;
        tick();
        req.iValid = 1'b0;
        guard = 0;
        while (issueCnt < 3 && guard < 100) begin tick(); guard++; end
        chk("mid:reachLimb2", issueCnt, 3);
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1; pend = 0;
        rstChk("mid");
        repeat (5) tick();
        chk("mid:noValid", validCnt - v0, 0);
    endtask

    initial begin
        logic [W-1:0] ones;
        int h;
        req.iValid = 0; req.iX = '0; req.iY = '0; req.iSub = 0; req.iCarryIn = 0;
        aReady = 0; aZ = '0; aCout = 0;
        resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        rstChk("rst");

        ones = '1;
        runOp(ones, 1, 0, 0, 2, -1, 0, "t1");
        runOp(256'hFFFF_FFF1, 256'hFF00_110C, 0, 0, 2, -1, 0, "t2a");
        runOp(256'hFF, 256'hFF, 0, 0, 1, -1, 0, "t2b");
        runOp(0, 1, 1, 0, 2, -1, 0, "t3a");
        runOp(5, 3, 1, 1, 3, -1, 0, "t3b");
        runOp(randW(), randW(), 0, 1, 2, 0, 0, "t4hang0");
        runOp(randW(), randW(), 0, 0, TO-1, -1, 0, "t4edge");
        runOp(randW(), randW(), 1, 0, 4, 2, 0, "t4hang2");

        spurious = 1;
        for (int i = 0; i < 3; i++)
            runOp(randW(), randW(), 0, 1'($urandom), $urandom_range(1, TO-1), -1, 1,
                  $sformatf("t5_%0d", i));
        spurious = 0;

        midReset();
        runOp(randW(), randW(), 0, 1, 2, -1, 0, "t6after");

        for (int i = 0; i < 20; i++) begin
            h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, LIMBS-1) : -1;
            spurious = 1'($urandom);
            runOp(randW(), randW(), 1'($urandom), 1'($urandom), $urandom_range(1, TO-1), h,
                  1'($urandom), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
